// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: state encoding and core reset constant shared by the stream controller
package seq_ctrl_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [2:0] CORE_RESET_STATE = 3'b000;
    typedef enum logic [1:0] {IDLE = ST_IDLE, SHIFT = ST_SHIFT, DONE = ST_DONE} state_t;
endpackage

// File: rtl/seq_stream_ctrl_if.sv
// seq_stream_ctrl_if: host-side stimulus/response handshake bundle
interface seq_stream_ctrl_if #(
    parameter int WIDTH = 8
);
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_exp;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] out_data;
    logic out_err;
    modport master (
        output in_valid, in_data, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );
    modport slave (
        input  in_valid, in_data, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/seq_bit_counter.sv
// seq_bit_counter: bit index counter with clear, enable and terminal count at WIDTH-1
module seq_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic [CW-1:0] cnt,
    output logic tc
);
    assign tc = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/seq_stream_ctrl.sv
// seq_stream_ctrl: plays stimulus words bit-serially into a Mealy core and checks its response
module seq_stream_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic clk,
    input  logic rst,
    seq_stream_ctrl_if.slave bus,
    output logic core_x,
    input  logic core_y,
    output logic core_rst_n,
    output logic busy
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_nx;
    logic [WIDTH-1:0] data_q, exp_q, out_q, out_nx;
    logic [CW-1:0] cnt, idx;
    logic tc, err_q, core_rst_q, accept, shift;
    assign accept = state == IDLE && bus.in_valid;
    assign shift = state == SHIFT;
    assign idx = MSB_FIRST != 0 ? CW'(WIDTH - 1) - cnt : cnt;
    seq_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(accept),
        .en(shift),
        .cnt(cnt),
        .tc(tc)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (accept) state_nx = SHIFT;
        if (shift && tc) state_nx = DONE;
        if (state == DONE && bus.out_ready) state_nx = IDLE;
    end
    always_comb begin
        out_nx = out_q;
        out_nx[idx] = core_y;
    end
    // core is released only while shifting, so each word starts from the core reset state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            exp_q <= '0;
            out_q <= '0;
            err_q <= 1'b0;
            core_rst_q <= 1'b0;
        end else if (accept) begin
            data_q <= bus.in_data;
            exp_q <= bus.in_exp;
            out_q <= '0;
            err_q <= 1'b0;
            core_rst_q <= 1'b1;
        end else if (shift) begin
            out_q <= out_nx;
            err_q <= tc ? out_nx != exp_q : err_q;
            core_rst_q <= !tc;
        end
    end
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_data = out_q;
    assign bus.out_err = err_q;
    assign core_x = shift && data_q[idx];
    assign core_rst_n = core_rst_q;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb_seq_stream_ctrl: drives two controllers (MSB/LSB first) attached to a reference Mealy core
module tb_seq_stream_ctrl;
    import seq_ctrl_pkg::*;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    seq_stream_ctrl_if #(.WIDTH(W)) a ();
    seq_stream_ctrl_if #(.WIDTH(W)) b ();
    logic ax, ay, arn, abusy, bx, by, brn, bbusy;
    logic [2:0] as, bs;
    int n_chk = 0;
    int n_fail = 0;
    seq_stream_ctrl #(.WIDTH(W), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .bus(a), .core_x(ax), .core_y(ay), .core_rst_n(arn), .busy(abusy)
    );
    seq_stream_ctrl #(.WIDTH(W), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .bus(b), .core_x(bx), .core_y(by), .core_rst_n(brn), .busy(bbusy)
    );
    function automatic logic cy(input logic [2:0] s, input logic x);
        return x ? (s != 3'd3) : (s >= 3'd2);
    endfunction
    function automatic logic [2:0] cn(input logic [2:0] s, input logic x);
        if (!x) return s == 3'd0 ? 3'd1 : 3'd2;
        return s == 3'd0 ? 3'd3 : s == 3'd3 ? 3'd4 : s == 3'd4 ? 3'd5 : s == 3'd5 ? 3'd0 : 3'd3;
    endfunction
    always_ff @(posedge clk or negedge arn)
        if (!arn) as <= CORE_RESET_STATE;
        else as <= cn(as, ax);
    always_ff @(posedge clk or negedge brn)
        if (!brn) bs <= CORE_RESET_STATE;
        else bs <= cn(bs, bx);
    assign ay = cy(as, ax);
    assign by = cy(bs, bx);
    function automatic logic [7:0] ref_word(input logic [7:0] d, input bit msb);
        logic [7:0] r;
        logic [2:0] s;
        int k;
        r = '0;
        s = CORE_RESET_STATE;
        for (int i = 0; i < W; i++) begin
            k = msb ? W - 1 - i : i;
            r[k] = cy(s, d[k]);
            s = cn(s, d[k]);
        end
        return r;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic play_a(input logic [7:0] d, input logic [7:0] e, input int hold);
        logic [7:0] xs, r;
        r = ref_word(d, 1'b1);
        a.in_valid = 1'b1;
        a.in_data = d;
        a.in_exp = e;
        @(negedge clk);
        chk("accept_busy", abusy, 1);
        chk("in_ready_shift", a.in_ready, 0);
        a.in_valid = 1'b0;
        a.in_data = 8'($urandom);
        a.in_exp = 8'($urandom);
        for (int i = 0; i < W; i++) begin
            xs[W-1-i] = ax;
            if (i == 0) chk("core_rst_n_shift", arn, 1);
            if (i == W - 1) chk("valid_early", a.out_valid, 0);
            @(negedge clk);
        end
        chk("core_x_seq", xs, d);
        chk("out_valid_latency", a.out_valid, 1);
        chk("out_data", a.out_data, r);
        chk("out_err", a.out_err, r != e);
        chk("core_rst_n_done", arn, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_data", a.out_data, r);
            chk("hold_valid", a.out_valid, 1);
            chk("hold_in_ready", a.in_ready, 0);
        end
    endtask
    task automatic release_a(input bit nxt, input logic [7:0] d, input logic [7:0] e);
        a.out_ready = 1'b1;
        if (nxt) begin
            a.in_valid = 1'b1;
            a.in_data = d;
            a.in_exp = e;
        end
        @(negedge clk);
        a.out_ready = 1'b0;
        chk("release_valid", a.out_valid, 0);
        chk("release_in_ready", a.in_ready, 1);
        chk("release_busy", abusy, 0);
    endtask
    initial begin
        logic [7:0] d, e, xs;
        a.in_valid = 1'b0; a.in_data = '0; a.in_exp = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.in_exp = '0; b.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", a.in_ready, 1);
        chk("rst_out_valid", a.out_valid, 0);
        chk("rst_out_data", a.out_data, 0);
        chk("rst_core_rst_n", arn, 0);
        chk("rst_busy", abusy, 0);
        rst = 1'b1;
        @(negedge clk);
        play_a(8'h00, 8'h3F, 0);
        chk("t1_const", a.out_data, 8'h3F);
        release_a(0, 0, 0);
        play_a(8'hFF, 8'hBB, 0);
        chk("t2_const", a.out_data, 8'hBB);
        release_a(0, 0, 0);
        play_a(8'hFF, 8'h00, 0);
        chk("t3_err", a.out_err, 1);
        release_a(0, 0, 0);
        play_a(8'h00, 8'h3F, 5);
        release_a(1, 8'hFF, 8'hBB);
        play_a(8'hFF, 8'hBB, 5);
        release_a(0, 0, 0);
        a.in_valid = 1'b1;
        a.in_data = 8'hFF;
        @(negedge clk);
        a.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_in_ready", a.in_ready, 1);
        chk("arst_out_valid", a.out_valid, 0);
        chk("arst_out_data", a.out_data, 0);
        chk("arst_out_err", a.out_err, 0);
        chk("arst_core_x", ax, 0);
        chk("arst_core_rst_n", arn, 0);
        chk("arst_busy", abusy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_no_valid", a.out_valid, 0);
        play_a(8'h00, 8'h3F, 0);
        chk("t5_const", a.out_data, 8'h3F);
        release_a(0, 0, 0);
        repeat (20) begin
            d = 8'($urandom);
            e = $urandom_range(0, 1) != 0 ? ref_word(d, 1'b1) : 8'($urandom);
            play_a(d, e, $urandom_range(0, 3));
            release_a(0, 0, 0);
        end
        for (int n = 0; n < 5; n++) begin
            d = n == 0 ? 8'h0F : 8'($urandom);
            b.in_valid = 1'b1;
            b.in_data = d;
            b.in_exp = ref_word(d, 1'b0);
            @(negedge clk);
            b.in_valid = 1'b0;
            for (int i = 0; i < W; i++) begin
                xs[i] = bx;
                @(negedge clk);
            end
            chk("lsb_core_x_seq", xs, d);
            chk("lsb_out_valid", b.out_valid, 1);
            chk("lsb_out_data", b.out_data, ref_word(d, 1'b0));
            chk("lsb_out_err", b.out_err, 0);
            b.out_ready = 1'b1;
            @(negedge clk);
            b.out_ready = 1'b0;
            chk("lsb_release", b.in_ready, 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
